// File: rtl/inst_encoder_pkg.sv
// Shared types and helpers for the RV32I instruction encoder.
package inst_encoder_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef enum logic [2:0] {
    FMT_R      = 3'd0,
    FMT_I      = 3'd1,
    FMT_ISHIFT = 3'd2,
    FMT_S      = 3'd3,
    FMT_B      = 3'd4,
    FMT_U      = 3'd5,
    FMT_J      = 3'd6,
    FMT_CSRI   = 3'd7
  } fmt_e;

  typedef struct packed {
    fmt_e               fmt;
    logic [6:0]         opcode;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [INST_W-1:0]  imm;
  } inst_req_t;

  typedef struct packed {
    logic               err;
    logic [INST_W-1:0]  inst;
  } fifo_ent_t;

  // True when v[31:msb] are all copies of the same bit (fits as a signed field).
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
    logic [31:0] s;
    s = 32'($signed(v) >>> msb);
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/inst_encoder_field_pack.sv
// Combinational field packer: request fields -> instruction word plus range error.
module inst_encoder_field_pack
  import inst_encoder_pkg::*;
(
  input  inst_req_t          req,
  output logic [INST_W-1:0]  inst_c,
  output logic               err_c
);

  logic [31:0] imm;
  assign imm = req.imm;

  always_comb begin
    inst_c      = '0;
    err_c       = 1'b0;
    inst_c[6:0] = req.opcode;
    case (req.fmt)
      FMT_R: inst_c[31:7] = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd};
      FMT_I: begin
        inst_c[31:7] = {imm[11:0], req.rs1, req.funct3, req.rd};
        err_c        = !fits_signed(imm, 11);
      end
      FMT_ISHIFT: begin
        inst_c[31:7] = {req.funct7, imm[4:0], req.rs1, req.funct3, req.rd};
        err_c        = |imm[31:5];
      end
      FMT_S: begin
        inst_c[31:7] = {imm[11:5], req.rs2, req.rs1, req.funct3, imm[4:0]};
        err_c        = !fits_signed(imm, 11);
      end
      FMT_B: begin
        inst_c[31:7] = {imm[12], imm[10:5], req.rs2, req.rs1, req.funct3, imm[4:1], imm[11]};
        err_c        = imm[0] || !fits_signed(imm, 12);
      end
      FMT_U: begin
        inst_c[31:7] = {imm[31:12], req.rd};
        err_c        = |imm[11:0];
      end
      FMT_J: begin
        inst_c[31:7] = {imm[20], imm[10:1], imm[11], imm[19:12], req.rd};
        err_c        = imm[0] || !fits_signed(imm, 20);
      end
      FMT_CSRI: begin
        // rs1 slot carries the 5-bit uimm taken from the rs2 input
        inst_c[31:7] = {imm[11:0], req.rs2, req.funct3, req.rd};
        err_c        = |imm[31:12];
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Streaming RV32I encoder: field packer feeding a 2-entry output FIFO and error counter.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_fmt,
  input  logic [6:0]            in_opcode,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [31:0]           in_imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_inst,
  output logic                  out_err,
  output logic [ERR_CNT_W-1:0]  err_count
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  inst_req_t          req;
  logic [INST_W-1:0]  inst_c;
  logic               err_c;

  fifo_ent_t          mem_q [DEPTH];
  fifo_ent_t          mem_n [DEPTH];
  logic               wr_q, wr_n, rd_q, rd_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [ERR_CNT_W-1:0] errc_n;
  logic               push, pop;

  always_comb begin
    req.fmt    = fmt_e'(in_fmt);
    req.opcode = in_opcode;
    req.rd     = in_rd;
    req.rs1    = in_rs1;
    req.rs2    = in_rs2;
    req.funct3 = in_funct3;
    req.funct7 = in_funct7;
    req.imm    = in_imm;
  end

  inst_encoder_field_pack u_pack (
    .req    (req),
    .inst_c (inst_c),
    .err_c  (err_c)
  );

  // Handshakes use only registered flags, so no in_* -> out_* path exists.
  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    mem_n  = mem_q;
    wr_n   = wr_q;
    rd_n   = rd_q;
    errc_n = err_count;
    if (push) begin
      mem_n[wr_q] = '{err: err_c, inst: inst_c};
      wr_n        = ~wr_q;
      if (err_c && (err_count != '1)) errc_n = err_count + ERR_CNT_W'(1);
    end
    if (pop) rd_n = ~rd_q;
    cnt_n = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      cnt_q     <= '0;
      err_count <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_err   <= 1'b0;
    end else begin
      mem_q     <= mem_n;
      wr_q      <= wr_n;
      rd_q      <= rd_n;
      cnt_q     <= cnt_n;
      err_count <= errc_n;
      in_ready  <= (cnt_n < CNT_W'(DEPTH));
      out_valid <= (cnt_n != '0);
      out_inst  <= mem_n[rd_n].inst;
      out_err   <= mem_n[rd_n].err;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: arithmetic reference model plus immediate round-trip decode.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  typedef struct {
    inst_req_t   req;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] err_count;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   model_errs = 0;
  int   ready_mode = 0;
  exp_t exp_q[$];

  inst_encoder #(.ERR_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_err(out_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference encoding from the format tables and immediate value ranges.
  function automatic exp_t model(input inst_req_t r);
    exp_t e;
    logic [31:0] u = r.imm;
    int signed   s = $signed(r.imm);
    logic [31:0] op = 32'(r.opcode), rd = 32'(r.rd), rs1 = 32'(r.rs1), rs2 = 32'(r.rs2);
    logic [31:0] f3 = 32'(r.funct3), f7 = 32'(r.funct7);
    e.req = r;
    e.err = 1'b0;
    case (r.fmt)
      FMT_R: e.inst = op | rd << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 | f7 << 25;
      FMT_I: begin
        e.inst = op | rd << 7 | f3 << 12 | rs1 << 15 | (u & 32'hFFF) << 20;
        e.err  = (s < -2048) || (s > 2047);
      end
      FMT_ISHIFT: begin
        e.inst = op | rd << 7 | f3 << 12 | rs1 << 15 | (u & 32'd31) << 20 | f7 << 25;
        e.err  = u > 32'd31;
      end
      FMT_S: begin
        e.inst = op | (u & 32'd31) << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 | ((u >> 5) & 32'd127) << 25;
        e.err  = (s < -2048) || (s > 2047);
      end
      FMT_B: begin
        e.inst = op | ((u >> 11) & 32'd1) << 7 | ((u >> 1) & 32'd15) << 8 | f3 << 12 | rs1 << 15
               | rs2 << 20 | ((u >> 5) & 32'd63) << 25 | ((u >> 12) & 32'd1) << 31;
        e.err  = (u[0] != 1'b0) || (s < -4096) || (s > 4095);
      end
      FMT_U: begin
        e.inst = op | rd << 7 | (u & 32'hFFFF_F000);
        e.err  = (u & 32'hFFF) != 0;
      end
      FMT_J: begin
        e.inst = op | rd << 7 | ((u >> 12) & 32'd255) << 12 | ((u >> 11) & 32'd1) << 20
               | ((u >> 1) & 32'd1023) << 21 | ((u >> 20) & 32'd1) << 31;
        e.err  = (u[0] != 1'b0) || (s < -(1 << 20)) || (s >= (1 << 20));
      end
      default: begin
        e.inst = op | rd << 7 | f3 << 12 | rs2 << 15 | (u & 32'hFFF) << 20;
        e.err  = u > 32'd4095;
      end
    endcase
    return e;
  endfunction

  // Core-style immediate extraction used for the round-trip check.
  function automatic logic [31:0] decode_imm(input fmt_e f, input logic [31:0] w);
    case (f)
      FMT_I:      return {{20{w[31]}}, w[31:20]};
      FMT_ISHIFT: return {27'd0, w[24:20]};
      FMT_S:      return {{20{w[31]}}, w[31:25], w[11:7]};
      FMT_B:      return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      FMT_U:      return {w[31:12], 12'd0};
      FMT_J:      return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      FMT_CSRI:   return {20'd0, w[31:20]};
      default:    return 32'd0;
    endcase
  endfunction

  function automatic inst_req_t mk(input fmt_e f, input logic [6:0] op, input logic [4:0] rd,
                                   input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [2:0] f3, input logic [31:0] imm);
    inst_req_t r;
    r.fmt = f; r.opcode = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
    r.funct3 = f3; r.funct7 = 7'd0; r.imm = imm;
    return r;
  endfunction

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 5))
      0: return $urandom;
      1: return 32'($signed($urandom_range(0, 4200)) - 2100);
      2: return 32'($signed($urandom_range(0, 10000)) - 5000);
      3: return $urandom << 12;
      4: return 32'($urandom_range(0, 40));
      default: return 32'($signed($urandom_range(0, 32'h0020_0100)) - 32'sh0010_0080);
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input inst_req_t r);
    int b = 0;
    exp_t e;
    in_fmt = r.fmt; in_opcode = r.opcode; in_rd = r.rd; in_rs1 = r.rs1; in_rs2 = r.rs2;
    in_funct3 = r.funct3; in_funct7 = r.funct7; in_imm = r.imm;
    in_valid = 1'b1;
    while (!in_ready && b < 200) begin @(negedge clk); b++; end
    if (!in_ready) begin
      chk("send_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    e = model(r);
    exp_q.push_back(e);
    if (e.err && model_errs < 65535) model_errs++;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    ready_mode = 1;
    while (exp_q.size() != 0 && b < 300) begin @(negedge clk); b++; end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk("drain_valid", 32'(out_valid), 32'd0);
  endtask

  // Consumer: ready pattern changes well after each rising edge.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (ready_mode)
        0: out_ready = 1'b0;
        1: out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops the scoreboard at each observed output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", out_inst, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          chk("out_inst", out_inst, e.inst);
          chk("out_err", 32'(out_err), 32'(e.err));
          if (!e.err && e.req.fmt != FMT_R)
            chk("roundtrip_imm", decode_imm(e.req.fmt, out_inst), e.req.imm);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    inst_req_t r;
    rst_n = 1'b0; in_valid = 1'b0;
    in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(in_ready), 32'd1);

    // Directed vectors with known encodings
    ready_mode = 1;
    @(negedge clk);
    send(mk(FMT_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF));
    chk("lat1_valid", 32'(out_valid), 32'd1);
    chk("vec_addi", out_inst, 32'hFFF0_0093);
    send(mk(FMT_B, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_FFFC));
    chk("vec_beq", out_inst, 32'hFE20_8EE3);
    send(mk(FMT_B, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3));
    chk("vec_beq_err", 32'(out_err), 32'd1);
    send(mk(FMT_J, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048));
    chk("vec_jal", out_inst, 32'h0010_00EF);
    send(mk(FMT_J, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0010_0000));
    chk("vec_jal_err", 32'(out_err), 32'd1);
    drain();
    chk("err_count_dir", 32'(err_count), 32'(model_errs));

    // Backpressure: two accepts fill the FIFO, the third waits for a pop
    ready_mode = 0;
    @(negedge clk);
    send(mk(FMT_U, 7'b0110111, 5'd3, 5'd0, 5'd0, 3'd0, 32'h1234_5000));
    send(mk(FMT_S, 7'b0100011, 5'd0, 5'd4, 5'd5, 3'd2, 32'hFFFF_F800));
    chk("full_in_ready", 32'(in_ready), 32'd0);
    fork
      send(mk(FMT_CSRI, 7'b1110011, 5'd6, 5'd0, 5'd9, 3'd5, 32'd768));
      begin
        repeat (3) @(negedge clk);
        chk("full_hold", 32'(in_ready), 32'd0);
        ready_mode = 1;
        @(negedge clk);
        chk("full_pop_pending", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("after_pop_ready", 32'(in_ready), 32'd1);
      end
    join
    drain();

    // Randomized traffic with random consumer stalls
    ready_mode = 2;
    @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      r.fmt    = fmt_e'($urandom_range(0, 7));
      r.opcode = 7'($urandom);
      r.rd     = 5'($urandom);
      r.rs1    = 5'($urandom);
      r.rs2    = 5'($urandom);
      r.funct3 = 3'($urandom);
      r.funct7 = 7'($urandom);
      r.imm    = rand_imm();
      send(r);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    drain();
    chk("err_count_rand", 32'(err_count), 32'(model_errs));

    // Asynchronous reset with a full FIFO
    ready_mode = 0;
    @(negedge clk);
    send(mk(FMT_B, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3));
    send(mk(FMT_R, 7'b0110011, 5'd7, 5'd8, 5'd9, 3'd0, 32'd0));
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd0);
    chk("async_err_count", 32'(err_count), 32'd0);
    chk("async_out_inst", out_inst, 32'd0);
    exp_q.delete();
    model_errs = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 1;
    repeat (3) @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    send(mk(FMT_I, 7'b0000011, 5'd10, 5'd11, 5'd0, 3'd2, 32'd2047));
    drain();
    chk("err_count_final", 32'(err_count), 32'(model_errs));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
